// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared binary32 field widths, constants and operand classes
package float_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = FRAC_W + 1;
  localparam int PROD_W   = 2 * MANT_W;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // Operand classes; denormals are folded into ZERO by the unpacker
  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fclass_t;

  // Signed zero / signed infinity encodings
  function automatic logic [31:0] signed_zero(input logic sign);
    return {sign, 31'h0};
  endfunction

  function automatic logic [31:0] signed_inf(input logic sign);
    return {sign, EXP_MAX, {FRAC_W{1'b0}}};
  endfunction

endpackage

// File: rtl/float_unpack.sv
// rtl/float_unpack.sv - split a binary32 word into sign, exponent, mantissa and class
module float_unpack
  import float_pkg::*;
(
  input  logic [31:0]       word,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant,
  output fclass_t           cls
);

  logic [FRAC_W-1:0] frac;

  assign frac = word[FRAC_W-1:0];

  // Classify; denormals flush to zero so their mantissa is forced to 0
  always_comb begin
    sign = word[31];
    exp  = word[30:FRAC_W];
    mant = {1'b1, frac};
    cls  = NORMAL;
    if (exp == '0) begin
      cls  = ZERO;
      mant = '0;
    end else if (exp == EXP_MAX) begin
      cls = (frac == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/float_multiplier.sv
// rtl/float_multiplier.sv - 3-stage pipelined binary32 multiplier, RNE, flush-to-zero
module float_multiplier
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done
);

  // Operand capture register
  logic        in_v;
  logic [31:0] in_a;
  logic [31:0] in_b;

  // Unpacked operands
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] ma, mb;
  fclass_t           ca, cb;

  // S1 results
  logic              s1_v;
  logic              s1_special;
  logic [31:0]       s1_spec_res;
  logic              s1_sign;
  logic signed [9:0] s1_exp;
  logic [MANT_W-1:0] s1_ma, s1_mb;

  // S2 results
  logic              s2_v;
  logic              s2_special;
  logic [31:0]       s2_spec_res;
  logic              s2_sign;
  logic signed [9:0] s2_exp;
  logic [PROD_W-1:0] s2_prod;

  // Capture operands on every start; the valid bit follows start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_v <= 1'b0;
      in_a <= '0;
      in_b <= '0;
    end else begin
      in_v <= start;
      if (start) begin
        in_a <= a;
        in_b <= b;
      end
    end
  end

  float_unpack u_unpack_a (
    .word (in_a),
    .sign (sa),
    .exp  (ea),
    .mant (ma),
    .cls  (ca)
  );

  float_unpack u_unpack_b (
    .word (in_b),
    .sign (sb),
    .exp  (eb),
    .mant (mb),
    .cls  (cb)
  );

  // ---------------- S1: classify, sign, exponent add ----------------
  logic              sign_c;
  logic signed [9:0] exp_sum_c;
  logic              special_c;
  logic [31:0]       spec_res_c;

  assign sign_c    = sa ^ sb;
  assign exp_sum_c = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;

  // Decide every non-normal outcome up front so S3 only has to select it
  always_comb begin
    special_c  = 1'b1;
    spec_res_c = QNAN;
    if (ca == NAN || cb == NAN ||
        (ca == ZERO && cb == INF) || (ca == INF && cb == ZERO)) begin
      spec_res_c = QNAN;
    end else if (ca == INF || cb == INF) begin
      spec_res_c = signed_inf(sign_c);
    end else if (ca == ZERO || cb == ZERO) begin
      spec_res_c = signed_zero(sign_c);
    end else begin
      special_c  = 1'b0;
    end
  end

  // S1 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v        <= 1'b0;
      s1_special  <= 1'b0;
      s1_spec_res <= '0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_ma       <= '0;
      s1_mb       <= '0;
    end else begin
      s1_v        <= in_v;
      s1_special  <= special_c;
      s1_spec_res <= spec_res_c;
      s1_sign     <= sign_c;
      s1_exp      <= exp_sum_c;
      s1_ma       <= ma;
      s1_mb       <= mb;
    end
  end

  // ---------------- S2: mantissa multiply ----------------
  logic [PROD_W-1:0] prod_c;

  assign prod_c = PROD_W'(s1_ma) * PROD_W'(s1_mb);

  // S2 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v        <= 1'b0;
      s2_special  <= 1'b0;
      s2_spec_res <= '0;
      s2_sign     <= 1'b0;
      s2_exp      <= '0;
      s2_prod     <= '0;
    end else begin
      s2_v        <= s1_v;
      s2_special  <= s1_special;
      s2_spec_res <= s1_spec_res;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_prod     <= prod_c;
    end
  end

  // ---------------- S3: normalize, round, pack ----------------
  logic              norm;
  logic [MANT_W-1:0] mant_pre;
  logic              guard_bit, round_bit, sticky_bit, round_up;
  logic [MANT_W:0]   mant_rnd;
  logic signed [9:0] exp_fin;
  logic [FRAC_W-1:0] frac_fin;
  logic [31:0]       packed_c;

  // Product of two [1,2) mantissas lies in [1,4); bit 47 set means >= 2.0
  always_comb begin
    norm = s2_prod[PROD_W-1];
    if (norm) begin
      mant_pre   = s2_prod[47:24];
      guard_bit  = s2_prod[23];
      round_bit  = s2_prod[22];
      sticky_bit = |s2_prod[21:0];
    end else begin
      mant_pre   = s2_prod[46:23];
      guard_bit  = s2_prod[22];
      round_bit  = s2_prod[21];
      sticky_bit = |s2_prod[20:0];
    end
  end

  // Round-to-nearest-even; a carry out of the mantissa bumps the exponent
  always_comb begin
    round_up = guard_bit & (round_bit | sticky_bit | mant_pre[0]);
    mant_rnd = {1'b0, mant_pre} + (MANT_W + 1)'(round_up);
    exp_fin  = s2_exp + signed'(10'(norm)) + signed'(10'(mant_rnd[MANT_W]));
    frac_fin = mant_rnd[MANT_W] ? mant_rnd[MANT_W-1:1] : mant_rnd[FRAC_W-1:0];
  end

  // Select special, overflow, underflow or normal packing
  always_comb begin
    packed_c = {s2_sign, exp_fin[EXP_W-1:0], frac_fin};
    if (s2_special) begin
      packed_c = s2_spec_res;
    end else if (exp_fin >= 10'sd255) begin
      packed_c = signed_inf(s2_sign);
    end else if (exp_fin <= 10'sd0) begin
      packed_c = signed_zero(s2_sign);
    end
  end

  // Output register; result only moves on the edge that raises done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= s2_v;
      if (s2_v) begin
        result <= packed_c;
      end
    end
  end

endmodule

// File: tb/tb_float_multiplier.sv
// tb/tb_float_multiplier.sv - scoreboard bench for float_multiplier against a reference model
module tb_float_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        done;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec;
  int          n_bad;
  int          cyc;
  logic [31:0] last_res;

  float_multiplier dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Reference: exact integer product, rounded by quotient/remainder comparison
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic            s;
    int              ex, ey, e, sh;
    longint unsigned fx, fy, p, q, rem, half;
    logic            xnan, ynan, xinf, yinf, xzero, yzero;
    s     = x[31] ^ y[31];
    ex    = int'(x[30:23]);
    ey    = int'(y[30:23]);
    fx    = longint'(x[22:0]);
    fy    = longint'(y[22:0]);
    xnan  = (ex == 255) && (fx != 0);
    ynan  = (ey == 255) && (fy != 0);
    xinf  = (ex == 255) && (fx == 0);
    yinf  = (ey == 255) && (fy == 0);
    xzero = (ex == 0);
    yzero = (ey == 0);
    if (xnan || ynan || (xzero && yinf) || (xinf && yzero)) return 32'h7FC00000;
    if (xinf || yinf) return {s, 8'hFF, 23'h0};
    if (xzero || yzero) return {s, 31'h0};
    p  = (fx + 64'h800000) * (fy + 64'h800000);
    e  = ex + ey - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: w[30:0] = 31'h0;
      1: w[30:0] = {8'hFF, 23'h0};
      2: begin w[30:23] = 8'hFF; if (w[22:0] == 0) w[0] = 1'b1; end
      3: begin w[30:23] = 8'h00; if (w[22:0] == 0) w[0] = 1'b1; end
      4, 5: w[30:23] = 8'($urandom_range(1, 254));
      default: w[30:23] = 8'($urandom_range(107, 147));
    endcase
    return w;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    exp_t t;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = x;
    b     = y;
    t.res = e;
    t.cyc = cyc + 1;
    sb_q.push_back(t);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: pop on each done, check value and latency; check hold otherwise
  always @(negedge clk) begin
    exp_t t;
    if (rst_n) begin
      if (done) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done result=%h required=no_done", result);
        end else begin
          t = sb_q.pop_front();
          if (result !== t.res || cyc != t.cyc + 3) begin
            n_bad++;
            $display("FAIL product result=%h cycle=%0d required=%h cycle=%0d",
                     result, cyc, t.res, t.cyc + 3);
          end
          last_res = t.res;
        end
      end else if (result !== last_res) begin
        n_vec++;
        n_bad++;
        $display("FAIL hold result=%h required=%h", result, last_res);
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    int          gap;
    n_vec    = 0;
    n_bad    = 0;
    cyc      = 0;
    last_res = 32'h0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    #12;
    n_vec++;
    if (result !== 32'h0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state result=%h done=%b required=00000000/0", result, done);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values, single-shot
    issue(32'h3FC00000, 32'h40000000, 32'h40400000);
    idle();
    drain();
    issue(32'hC0000000, 32'h3F000000, 32'hBF800000);
    issue(32'h3F800001, 32'h3F800001, 32'h3F800002);
    issue(32'h00000000, 32'h7F800000, 32'h7FC00000);
    issue(32'h7FC00000, 32'h3F800000, 32'h7FC00000);
    issue(32'hFF800000, 32'h40000000, 32'hFF800000);
    issue(32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
    issue(32'h00800000, 32'h00800000, 32'h00000000);
    issue(32'h00000001, 32'h3F800000, 32'h00000000);
    idle();
    drain();

    // Four back-to-back distinct operations
    issue(32'h40400000, 32'h40800000, 32'h41400000);
    issue(32'hBFC00000, 32'hBFC00000, 32'h40100000);
    issue(32'h3F800000, 32'hC1200000, 32'hC1200000);
    issue(32'h80000000, 32'h3F800000, 32'h80000000);
    idle();
    drain();

    // Reset one cycle after start discards the in-flight operation
    issue(32'h40000000, 32'h40000000, 32'h40800000);
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (result !== 32'h0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_op result=%h done=%b required=00000000/0", result, done);
    end
    sb_q.delete();
    last_res = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Randomized traffic with occasional idle gaps
    for (int i = 0; i < 400; i++) begin
      x = rand_op();
      y = rand_op();
      issue(x, y, model(x, y));
      gap = $urandom_range(0, 3);
      if (gap == 0) idle();
    end
    idle();
    drain();
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
